// File: rtl/regfile_pkg.sv
// Shared types and sizing constants for the regfile_sb register file and its read ports.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

   // The busy counter needs one bit more than the address so it can hold 2**ADDR_W.
   function automatic int cnt_width(input int addr_w);
      return addr_w + 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(ADDR_W_DEF);

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: stored-state mux, hardwired-zero register and optional
// same-cycle write forwarding (REGFILE_BYPASS_EN).
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0]                    addr,
   input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs,
   input  logic [(1<<ADDR_W)-1:0]               busy,
   input  logic                                 wa_en,
   input  logic [ADDR_W-1:0]                    wa_addr,
   input  logic [DATA_W-1:0]                    wa_data,
   input  logic                                 wb_en,
   input  logic [ADDR_W-1:0]                    wb_addr,
   input  logic [DATA_W-1:0]                    wb_data,
   input  logic                                 sb_set,
   input  logic [ADDR_W-1:0]                    sb_addr,
   output logic [DATA_W-1:0]                    data,
   output logic                                 busy_bit
);

`ifndef REGFILE_BYPASS_EN
   logic unused_bypass;
   assign unused_bypass = ^{wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, sb_set, sb_addr};
`endif

   always_comb begin
      data     = regs[addr];
      busy_bit = busy[addr];
`ifdef REGFILE_BYPASS_EN
      // Port A is younger in program order, so it overrides port B.
      if (wb_en && (wb_addr == addr)) data = wb_data;
      if (wa_en && (wa_addr == addr)) data = wa_data;
      if (wb_en && (wb_addr == addr) && !(sb_set && (sb_addr == addr))) busy_bit = 1'b0;
`endif
      if ((ZERO_REG != 0) && (addr == '0)) begin
         data     = '0;
         busy_bit = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with pending-write scoreboard and busy counter.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and busy-clears to the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREAD*ADDR_W-1:0] rd_addr,
   output logic [NREAD*DATA_W-1:0] rd_data,
   output logic [NREAD-1:0]        rd_busy,
   input  logic                    wa_en,
   input  logic [ADDR_W-1:0]       wa_addr,
   input  logic [DATA_W-1:0]       wa_data,
   input  logic                    wb_en,
   input  logic [ADDR_W-1:0]       wb_addr,
   input  logic [DATA_W-1:0]       wb_data,
   input  logic                    sb_set,
   input  logic [ADDR_W-1:0]       sb_addr,
   output logic [ADDR_W:0]         busy_cnt,
   output logic                    any_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = cnt_width(ADDR_W);

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic [DEPTH-1:0]             busy;
   logic [DEPTH-1:0]             busy_nxt;
   logic                         zero_wa, zero_wb, zero_sb;
   logic                         set_eff, clr_eff;
   logic [CNT_W-1:0]             cnt_nxt;

   assign zero_wa = (ZERO_REG != 0) && (wa_addr == '0);
   assign zero_wb = (ZERO_REG != 0) && (wb_addr == '0);
   assign zero_sb = (ZERO_REG != 0) && (sb_addr == '0);

   // A set wins over a clear of the same register in the same cycle.
   always_comb begin
      busy_nxt = busy;
      if (wb_en) busy_nxt[wb_addr] = 1'b0;
      if (sb_set && !zero_sb) busy_nxt[sb_addr] = 1'b1;
   end

   // Only bits that actually change move the counter, so it can never wrap.
   assign set_eff = sb_set && !zero_sb && !busy[sb_addr];
   assign clr_eff = wb_en && busy[wb_addr] && !(sb_set && !zero_sb && (sb_addr == wb_addr));
   assign cnt_nxt = busy_cnt + {{(CNT_W-1){1'b0}}, set_eff} - {{(CNT_W-1){1'b0}}, clr_eff};

   always_ff @(posedge clk) begin
      if (reset) begin
         regs     <= '0;
         busy     <= '0;
         busy_cnt <= '0;
         any_busy <= 1'b0;
      end else begin
         if (wb_en && !zero_wb) regs[wb_addr] <= wb_data;
         if (wa_en && !zero_wa) regs[wa_addr] <= wa_data;
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
         any_busy <= (cnt_nxt != '0);
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
         .regs     (regs),
         .busy     (busy),
         .wa_en    (wa_en),
         .wa_addr  (wa_addr),
         .wa_data  (wa_data),
         .wb_en    (wb_en),
         .wb_addr  (wb_addr),
         .wb_data  (wb_data),
         .sb_set   (sb_set),
         .sb_addr  (sb_addr),
         .data     (rd_data[i*DATA_W +: DATA_W]),
         .busy_bit (rd_busy[i])
      );
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read, dual-write register file with a per-register pending-write scoreboard, for the MIPS core's decode/writeback boundary. Port A takes single-cycle ALU writeback. Port B takes long-latency writeback (loads, mul/div) and clears scoreboard bits, so decode can detect RAW/WAW hazards and stall. Register 0 is hardwired to zero when enabled.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads zero and ignores writes and sets

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers, busy bits and counter
- rd_addr  in  NREAD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  packed read data, combinational
- rd_busy  out  NREAD  scoreboard bit of each addressed register, combinational
- wa_en  in  1  port A write enable
- wa_addr  in  ADDR_W  port A address
- wa_data  in  DATA_W  port A data
- wb_en  in  1  port B write enable; also clears the busy bit of wb_addr
- wb_addr  in  ADDR_W  port B address
- wb_data  in  DATA_W  port B data
- sb_set  in  1  mark sb_addr pending (issue of a long-latency op)
- sb_addr  in  ADDR_W  register to mark
- busy_cnt  out  ADDR_W+1  number of busy registers, registered
- any_busy  out  1  busy_cnt != 0, registered

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus a 2**ADDR_W busy-bit vector.
- Reset (clk edge with reset=1): all registers 0, all busy bits 0, busy_cnt 0, any_busy 0. Reset overrides every same-cycle write/set.
- Writes: on the rising edge, wa_en writes wa_data to wa_addr; wb_en writes wb_data to wb_addr.
- Same-address dual write: port A data is stored (A is younger in program order). Port B still clears the busy bit.
- Scoreboard per register r, next-state priority: sb_set to r sets the bit, else wb_en to r clears it, else it holds. A simultaneous set and clear of the same register leaves the bit set.
- Port A never touches busy bits.
- busy_cnt next = popcount of the next busy vector, computed as current + sets − clears with the same priority. Range 0..2**ADDR_W (the +1 bit covers the all-busy case). It never wraps.
- ZERO_REG=1: address 0 reads data 0 and busy 0. Writes and sb_set to 0 are ignored and do not change busy_cnt. busy_cnt maximum becomes 2**ADDR_W−1.
- Reads: rd_data[i] and rd_busy[i] reflect the stored state, modified by the bypass described under Configuration.

## Timing
- Read latency: 0 cycles, combinational from rd_addr.
- Write latency: stored on the edge. Without bypass, readable the following cycle.
- busy_cnt and any_busy update on the same edge as the busy vector. They are never combinational from inputs.
- No handshake; all enables are single-cycle strobes sampled every edge.
- A reset asserted mid-operation discards pending busy state. Writeback arriving after reset is written normally; the clear it carries has no effect on an already-clear bit.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - A read whose address matches an active same-cycle write returns that write data, with port A priority over port B.
  - rd_busy reads 0 if wb_en clears that register this cycle and no same-cycle sb_set targets it.
  - Address 0 is never bypassed when ZERO_REG=1.
- Undefined: reads return stored state only. New data and busy-clear become visible one cycle after the write edge.
- busy_cnt is unaffected by the macro.

## Structure
- Shared package regfile_pkg:
  - default DATA_W and ADDR_W constants
  - reg_addr_t and reg_data_t typedefs
  - popcount width helper constant
- Sub-module regfile_read_port: one combinational read mux with zero-register and bypass logic, instantiated NREAD times via generate.
- The scoreboard and counter stay in the top level.

## Test plan
- Reset then read: write r5=0xDEAD_BEEF, assert reset one cycle → all rd_data 0, rd_busy 0, busy_cnt 0.
- Dual write collision: wa r7=0x1111, wb r7=0x2222 same cycle after sb_set r7 → r7 reads 0x1111, rd_busy 0, busy_cnt back to 0.
- Scoreboard set/clear overlap: sb_set r3 in cycle 0; in cycle 1 sb_set r3 and wb_en r3 → busy stays 1, busy_cnt=1. Clear-only in cycle 2 → busy_cnt=0, any_busy 0.
- Zero register: wa r0=0xFFFF_FFFF and sb_set r0 → r0 reads 0, rd_busy 0, busy_cnt unchanged.
- Bypass: wa r9=0xABCD with rd_addr r9 same cycle → with REGFILE_BYPASS_EN rd_data=0xABCD that cycle; without it, old value that cycle and 0xABCD the next.
- Full scoreboard: sb_set r1..r31 on 31 consecutive cycles (ZERO_REG=1) → busy_cnt=31, then 31 wb clears → busy_cnt=0, no wrap.
